// File: rtl/sine_dds_pkg.sv
// rtl/sine_dds_pkg.sv - shared widths, quadrant type and quarter-wave address folding for sine_dds_ctrl
package sine_dds_pkg;

  localparam int TBL_AW = 8;
  localparam int TBL_DW = 8;
  localparam int OUT_W  = 9;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  // Odd quadrants run the quarter-wave table backwards (255 - idx).
  function automatic logic [TBL_AW-1:0] fold_addr(input quadrant_t q,
                                                   input logic [TBL_AW-1:0] idx);
    case (q)
      Q1, Q3:  fold_addr = ~idx;
      default: fold_addr = idx;
    endcase
  endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// rtl/sine_phase_acc.sv - phase accumulator: load has priority over step, silent modulo wrap
module sine_phase_acc #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               phase_load,
  input  logic [PHASE_W-1:0] phase_init,
  input  logic               issue,
  input  logic [PHASE_W-1:0] phase_step,
  output logic [PHASE_W-1:0] phase
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (phase_load) begin
      phase <= phase_init;
    end else if (issue) begin
      phase <= phase + phase_step;
    end
  end

endmodule

// File: rtl/sine_dds_ctrl.sv
// rtl/sine_dds_ctrl.sv - full-wave sine DDS sequencing a quarter-wave sin_table, valid/ready output
// Optional SINE_DDS_AMP_EN adds an amp input and one amplitude-scaling stage.
module sine_dds_ctrl
  import sine_dds_pkg::*;
#(
  parameter int PHASE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    phase_load,
  input  logic [PHASE_W-1:0]      phase_init,
  input  logic [PHASE_W-1:0]      phase_step,
  output logic                    tbl_rd,
  output logic [TBL_AW-1:0]       tbl_addr,
  input  logic [TBL_DW-1:0]       tbl_dout,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
`ifdef SINE_DDS_AMP_EN
  input  logic [7:0]              amp,
`endif
  output logic                    busy
);

  logic [PHASE_W-1:0]      phase;
  logic                    adv;
  logic                    issue;
  logic                    neg;
  quadrant_t               q;
  logic                    p1_valid;
  logic                    p1_neg;
  logic signed [OUT_W-1:0] raw;
  logic                    unused_phase_lsbs;

  assign q        = quadrant_t'(phase[PHASE_W-1 -: 2]);
  assign neg      = phase[PHASE_W-1];
  assign tbl_addr = fold_addr(q, phase[PHASE_W-3 -: TBL_AW]);
  assign unused_phase_lsbs = ^phase[PHASE_W-TBL_AW-3:0];

  // Gated by rst_n so the table strobe is quiet the moment reset asserts.
  assign adv    = !sample_valid || sample_ready;
  assign issue  = rst_n && en && adv && !phase_load;
  assign tbl_rd = issue;

  sine_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase_load (phase_load),
    .phase_init (phase_init),
    .issue      (issue),
    .phase_step (phase_step),
    .phase      (phase)
  );

  // Table data arrives the cycle after the read and is held by the ROM during stalls.
  assign raw = p1_neg ? -$signed({1'b0, tbl_dout}) : $signed({1'b0, tbl_dout});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_neg   <= 1'b0;
    end else if (adv) begin
      p1_valid <= issue;
      p1_neg   <= neg;
    end
  end

`ifdef SINE_DDS_AMP_EN
  logic                    p2_valid;
  logic signed [OUT_W-1:0] p2_raw;
  logic signed [17:0]      prod;

  // Arithmetic shift of the product floors toward -inf.
  assign prod = p2_raw * $signed({1'b0, amp});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_valid     <= 1'b0;
      p2_raw       <= '0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else if (adv) begin
      p2_valid     <= p1_valid;
      if (p1_valid) p2_raw <= raw;
      sample_valid <= p2_valid;
      if (p2_valid) sample_out <= OUT_W'(prod >>> 8);
    end
  end

  assign busy = rst_n && (en || p1_valid || p2_valid || sample_valid);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else if (adv) begin
      sample_valid <= p1_valid;
      if (p1_valid) sample_out <= raw;
    end
  end

  assign busy = rst_n && (en || p1_valid || sample_valid);
`endif

endmodule

// File: tb/tb_sine_dds_ctrl.sv
// tb/tb_sine_dds_ctrl.sv - directed self-checking bench for sine_dds_ctrl with an identity sin_table model
module tb_sine_dds_ctrl;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              phase_load = 1'b0;
  logic [15:0]       phase_init = '0;
  logic [15:0]       phase_step = '0;
  logic              tbl_rd;
  logic [7:0]        tbl_addr;
  logic [7:0]        tbl_dout = '0;
  logic signed [8:0] sample_out;
  logic              sample_valid;
  logic              sample_ready = 1'b1;
  logic              busy;
  logic [7:0]        amp = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Table stand-in: table[a] = a, registered read, holds when rd is low.
  always @(posedge clk) if (tbl_rd) tbl_dout <= tbl_addr;

  sine_dds_ctrl #(.PHASE_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .phase_load   (phase_load),
    .phase_init   (phase_init),
    .phase_step   (phase_step),
    .tbl_rd       (tbl_rd),
    .tbl_addr     (tbl_addr),
    .tbl_dout     (tbl_dout),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
`ifdef SINE_DDS_AMP_EN
    .amp          (amp),
`endif
    .busy         (busy)
  );

  function automatic logic [7:0] f_addr(input logic [15:0] p);
    int idx;
    idx = int'(p[13:6]);
    return p[14] ? 8'(255 - idx) : 8'(idx);
  endfunction

  function automatic logic signed [8:0] f_samp(input logic [15:0] p);
    logic [8:0] m;
    m = {1'b0, f_addr(p)};
    return p[15] ? -$signed(m) : $signed(m);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; phase_load = 1'b0; sample_ready = 1'b1;
    phase_step = '0; phase_init = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0;
    #1;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", sample_valid); end
    checks++; if (sample_out !== 9'sd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", sample_out); end
    checks++; if (tbl_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got=%0b exp=0", tbl_rd); end
    checks++; if (tbl_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", tbl_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [15:0] p;
    do_reset();
    phase_step = 16'h0040; en = 1'b1;
    for (int e = 0; e < 300; e++) begin
      #1;
      p = 16'(e * 64);
      checks++; if (tbl_addr !== f_addr(p)) begin errors++; $display("FAIL sweep_addr e=%0d got=%0d exp=%0d", e, tbl_addr, f_addr(p)); end
      checks++; if (tbl_rd !== 1'b1) begin errors++; $display("FAIL sweep_rd e=%0d got=%0b exp=1", e, tbl_rd); end
      if (e < 2) begin
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL sweep_latency e=%0d got=%0b exp=0", e, sample_valid); end
      end else begin
        p = 16'((e - 2) * 64);
        checks++; if (sample_valid !== 1'b1 || sample_out !== f_samp(p)) begin
          errors++; $display("FAIL sweep_sample e=%0d got=%0b/%0d exp=1/%0d", e, sample_valid, sample_out, f_samp(p));
        end
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_negative();
    logic [15:0] p;
    do_reset();
    phase_init = 16'h8000; phase_load = 1'b1; phase_step = 16'h0040; en = 1'b1;
    #1;
    checks++; if (tbl_rd !== 1'b0) begin errors++; $display("FAIL load_no_issue got=%0b exp=0", tbl_rd); end
    @(negedge clk);
    phase_load = 1'b0;
    for (int e = 0; e < 300; e++) begin
      #1;
      p = 16'(32768 + e * 64);
      checks++; if (tbl_addr !== f_addr(p)) begin errors++; $display("FAIL neg_addr e=%0d got=%0d exp=%0d", e, tbl_addr, f_addr(p)); end
      if (e >= 2) begin
        p = 16'(32768 + (e - 2) * 64);
        checks++; if (sample_valid !== 1'b1 || sample_out !== f_samp(p)) begin
          errors++; $display("FAIL neg_sample e=%0d got=%0b/%0d exp=1/%0d", e, sample_valid, sample_out, f_samp(p));
        end
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    logic [8:0]  exp_addr [0:3] = '{9'd0, 9'd255, 9'd0, 9'd255};
    logic signed [8:0] exp_samp [0:3] = '{9'sd0, 9'sd255, 9'sd0, -9'sd255};
    do_reset();
    phase_init = 16'h8000; phase_load = 1'b1; phase_step = 16'hC000;
    @(negedge clk);
    phase_load = 1'b0; en = 1'b1;
    for (int e = 0; e < 10; e++) begin
      #1;
      checks++; if ({1'b0, tbl_addr} !== exp_addr[e % 4]) begin errors++; $display("FAIL wrap_addr e=%0d got=%0d exp=%0d", e, tbl_addr, exp_addr[e % 4]); end
      if (e >= 2) begin
        checks++; if (sample_valid !== 1'b1 || sample_out !== exp_samp[(e - 2) % 4]) begin
          errors++; $display("FAIL wrap_sample e=%0d got=%0b/%0d exp=1/%0d", e, sample_valid, sample_out, exp_samp[(e - 2) % 4]);
        end
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    phase_step = 16'h0040; en = 1'b1;
    repeat (6) @(negedge clk);
    sample_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); #1;
      checks++; if (sample_valid !== 1'b1 || sample_out !== 9'sd4) begin errors++; $display("FAIL stall_hold s=%0d got=%0b/%0d exp=1/4", s, sample_valid, sample_out); end
      checks++; if (tbl_rd !== 1'b0) begin errors++; $display("FAIL stall_rd s=%0d got=%0b exp=0", s, tbl_rd); end
      checks++; if (tbl_addr !== 8'd6) begin errors++; $display("FAIL stall_phase s=%0d got=%0d exp=6", s, tbl_addr); end
    end
    sample_ready = 1'b1;
    for (int e = 12; e <= 20; e++) begin
      @(negedge clk); #1;
      checks++; if (sample_valid !== 1'b1 || sample_out !== 9'(e - 7)) begin errors++; $display("FAIL resume_sample e=%0d got=%0b/%0d exp=1/%0d", e, sample_valid, sample_out, e - 7); end
      checks++; if (tbl_addr !== 8'(e - 5)) begin errors++; $display("FAIL resume_addr e=%0d got=%0d exp=%0d", e, tbl_addr, e - 5); end
    end
    en = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    phase_init = 16'h0140; phase_load = 1'b1;
    @(negedge clk);
    phase_load = 1'b0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    #1;
    checks++; if (tbl_rd !== 1'b0 || busy !== 1'b1 || sample_valid !== 1'b0) begin
      errors++; $display("FAIL drain_p1 got rd=%0b busy=%0b valid=%0b exp 0/1/0", tbl_rd, busy, sample_valid);
    end
    @(negedge clk); #1;
    checks++; if (sample_valid !== 1'b1 || sample_out !== 9'sd5 || busy !== 1'b1) begin
      errors++; $display("FAIL drain_out got valid=%0b out=%0d busy=%0b exp 1/5/1", sample_valid, sample_out, busy);
    end
    @(negedge clk); #1;
    checks++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drain_idle got valid=%0b busy=%0b exp 0/0", sample_valid, busy); end
    @(negedge clk); #1;
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL drain_extra got=%0b exp=0", sample_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    phase_step = 16'h0040; en = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sample_valid !== 1'b0 || sample_out !== 9'sd0) begin errors++; $display("FAIL async_out got=%0b/%0d exp=0/0", sample_valid, sample_out); end
    checks++; if (tbl_rd !== 1'b0 || busy !== 1'b0 || tbl_addr !== 8'd0) begin
      errors++; $display("FAIL async_ctl got rd=%0b busy=%0b addr=%0d exp 0/0/0", tbl_rd, busy, tbl_addr);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef SINE_DDS_AMP_EN
  task automatic test_amp();
    logic [15:0]       v_phase [0:2] = '{16'h4000, 16'h4000, 16'hC000};
    logic [7:0]        v_amp   [0:2] = '{8'h80, 8'h00, 8'h80};
    logic signed [8:0] v_exp   [0:2] = '{9'sd127, 9'sd0, -9'sd128};
    for (int v = 0; v < 3; v++) begin
      do_reset();
      amp = v_amp[v]; phase_init = v_phase[v]; phase_load = 1'b1;
      @(negedge clk);
      phase_load = 1'b0; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk); #1;
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL amp_latency v=%0d got=%0b exp=0", v, sample_valid); end
      @(negedge clk); #1;
      checks++; if (sample_valid !== 1'b1 || sample_out !== v_exp[v]) begin
        errors++; $display("FAIL amp_sample v=%0d got=%0b/%0d exp=1/%0d", v, sample_valid, sample_out, v_exp[v]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_negative();
    test_wrap();
    test_backpressure();
    test_drain();
    test_async_reset();
`ifdef SINE_DDS_AMP_EN
    test_amp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
